gates_checker: RTL

GATES_CHECKER -- requirements
Module: gates_checker

---
 rtl/gates_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gates_checker.sv
// Truth-table checker for a two-input gate block: drives the four (a,b) vectors,
// waits SETTLE cycles on each, then compares seven gate responses.
module gates_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_and,
  input  logic       y_or,
  input  logic       y_not,
  input  logic       y_nand,
  input  logic       y_nor,
  input  logic       y_xor,
  input  logic       y_xnor,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic       a_n, b_n, busy_n, done_n, pass_n;
  logic [2:0] err_count_n;
  logic [6:0] fail_mask_n;
  logic [6:0] expected, actual, mismatch;

  // Bit order of both vectors matches fail_mask: [0]and .. [6]xnor.
  assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign actual   = {y_xnor, y_xor, y_nor, y_nand, y_not, y_or, y_and};
  assign mismatch = actual ^ expected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 7'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      a         <= a_n;
      b         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_count_n;
      fail_mask <= fail_mask_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    cnt_n       = cnt;
    a_n         = a;
    b_n         = b;
    busy_n      = busy;
    done_n      = done;
    pass_n      = pass;
    err_count_n = err_count;
    fail_mask_n = fail_mask;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_SETTLE;
          idx_n       = 2'd0;
          cnt_n       = RELOAD;
          a_n         = 1'b0;
          b_n         = 1'b0;
          busy_n      = 1'b1;
          pass_n      = 1'b0;
          err_count_n = 3'd0;
          fail_mask_n = 7'd0;
        end
      end
      S_SETTLE: begin
        if (cnt == 4'd0) state_n = S_CHECK;
        else             cnt_n   = cnt - 4'd1;
      end
      S_CHECK: begin
        fail_mask_n = fail_mask | mismatch;
        if (|mismatch) err_count_n = err_count + 3'd1;
        // Last vector finishes the run; pass includes this vector's result.
        if (idx == 2'd3) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = ~|(fail_mask | mismatch);
        end else begin
          state_n    = S_SETTLE;
          idx_n      = idx + 2'd1;
          {a_n, b_n} = idx + 2'd1;
          cnt_n      = RELOAD;
        end
      end
      S_DONE: begin
        done_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
